// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle between the 5-stage datapath and hazard_ctrl_unit.
// The master modport belongs to the pipeline and the slave modport to the hazard controller.
interface hazard_ctrl_unit_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [XLEN-1:0]   ex_opa;
    logic [XLEN-1:0]   ex_opb;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_load;
    logic              ex_redirect;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [XLEN-1:0]   mem_fwd_data;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic [XLEN-1:0]   wb_data;
    logic              mem_req;
    logic              data_mem_valid;
    logic [XLEN-1:0]   alu_in_a;
    logic [XLEN-1:0]   alu_in_b;
    logic              stall_fetch;
    logic              stall_decode;
    logic              bubble_ex;
    logic              flush_id;
    logic              stall_back;
    logic              mem_timeout_err;
    logic [1:0]        hz_state;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_opa, ex_opb,
               ex_rd, ex_reg_write, ex_load, ex_redirect, mem_rd, mem_reg_write,
               mem_fwd_data, wb_rd, wb_reg_write, wb_data, mem_req, data_mem_valid,
        input  alu_in_a, alu_in_b, stall_fetch, stall_decode, bubble_ex, flush_id,
               stall_back, mem_timeout_err, hz_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_opa, ex_opb,
               ex_rd, ex_reg_write, ex_load, ex_redirect, mem_rd, mem_reg_write,
               mem_fwd_data, wb_rd, wb_reg_write, wb_data, mem_req, data_mem_valid,
        output alu_in_a, alu_in_b, stall_fetch, stall_decode, bubble_ex, flush_id,
               stall_back, mem_timeout_err, hz_state
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: MEM/WB operand forwarding, load-use stall, redirect flush, memory-wait freeze.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and redirect counters.
//
// state      | meaning
// S_RUN      | normal flow; load-use stall, redirect start or freeze entry
// S_MEM_WAIT | data memory outstanding; whole pipe frozen
// S_REDIRECT | remaining wrong-path bubbles after a taken branch/jump
module hazard_ctrl_unit #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    hazard_ctrl_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc_o,
    output logic [CNT_W-1:0] perf_flush_cnt_o
`endif
);

    localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;

    logic            load_use;
    logic            mem_block;
    logic            stall_fetch, stall_decode, bubble_ex, flush_id, stall_back;
    logic            timeout_err, redirect_acc;

    assign load_use = hz.ex_load && hz.ex_reg_write && (hz.ex_rd != '0)
                      && ((hz.id_use1 && (hz.id_rs1 == hz.ex_rd))
                       || (hz.id_use2 && (hz.id_rs2 == hz.ex_rd)));
    assign mem_block = hz.mem_req && !hz.data_mem_valid;

    // MEM result is younger than WB, so it wins; x0 is never forwarded.
    always_comb begin
        hz.alu_in_a = hz.ex_opa;
        hz.alu_in_b = hz.ex_opb;
        if (!rst_i) begin
            if (hz.mem_reg_write && (hz.mem_rd != '0) && (hz.mem_rd == hz.ex_rs1))
                hz.alu_in_a = hz.mem_fwd_data;
            else if (hz.wb_reg_write && (hz.wb_rd != '0) && (hz.wb_rd == hz.ex_rs1))
                hz.alu_in_a = hz.wb_data;
            if (hz.mem_reg_write && (hz.mem_rd != '0) && (hz.mem_rd == hz.ex_rs2))
                hz.alu_in_b = hz.mem_fwd_data;
            else if (hz.wb_reg_write && (hz.wb_rd != '0) && (hz.wb_rd == hz.ex_rs2))
                hz.alu_in_b = hz.wb_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        stall_fetch  = 1'b0;
        stall_decode = 1'b0;
        bubble_ex    = 1'b0;
        flush_id     = 1'b0;
        stall_back   = 1'b0;
        timeout_err  = 1'b0;
        redirect_acc = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_RUN: begin
                    if (mem_block) begin
                        stall_fetch  = 1'b1;
                        stall_decode = 1'b1;
                        stall_back   = 1'b1;
                        wcnt_d       = '0;
                        state_d      = S_MEM_WAIT;
                    end else if (hz.ex_redirect) begin
                        flush_id     = 1'b1;
                        bubble_ex    = 1'b1;
                        redirect_acc = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            cnt_d   = 3'(FLUSH_CYCLES - 1);
                            state_d = S_REDIRECT;
                        end
                    end else if (load_use) begin
                        stall_fetch  = 1'b1;
                        stall_decode = 1'b1;
                        bubble_ex    = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    stall_fetch  = 1'b1;
                    stall_decode = 1'b1;
                    stall_back   = 1'b1;
                    if (hz.data_mem_valid) begin
                        wcnt_d  = '0;
                        state_d = S_RUN;
                    end else if ((MEM_TIMEOUT != 0) && (wcnt_q == WW'(MEM_TIMEOUT - 1))) begin
                        timeout_err = 1'b1;
                        wcnt_d      = '0;
                        state_d     = S_RUN;
                    end else begin
                        wcnt_d = wcnt_q + WW'(1);
                    end
                end
                S_REDIRECT: begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (mem_block) begin
                        stall_fetch  = 1'b1;
                        stall_decode = 1'b1;
                        stall_back   = 1'b1;
                    end else if (cnt_q <= 3'd1) begin
                        // cnt counts this bubble too: leaving when it would reach zero
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign hz.stall_fetch     = stall_fetch;
    assign hz.stall_decode    = stall_decode;
    assign hz.bubble_ex       = bubble_ex;
    assign hz.flush_id        = flush_id;
    assign hz.stall_back      = stall_back;
    assign hz.mem_timeout_err = timeout_err;
    assign hz.hz_state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall_fetch && !(&perf_stall_q))
                perf_stall_q <= perf_stall_q + CNT_W'(1);
            if (redirect_acc && !(&perf_flush_q))
                perf_flush_q <= perf_flush_q + CNT_W'(1);
        end
    end

    assign perf_stall_cyc_o = perf_stall_q;
    assign perf_flush_cnt_o = perf_flush_q;
`else
    logic unused_acc;
    assign unused_acc = redirect_acc;
`endif

endmodule
